pla_fsm_engine: RTL and testbench

//  Parametrised, run-time programmable two-level (AND/OR plane) FSM engine. Replaces fixed,

---
 rtl/pla_fsm_pkg.sv | 24 ++
 rtl/pla_fsm_engine_term.sv | 51 +++++
 rtl/pla_fsm_engine.sv | 106 ++++++++++
 tb/tb_pla_fsm_engine.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/pla_fsm_pkg.sv
// Shared constants and helpers for the programmable AND/OR-plane FSM engine.
// Default geometry matches the benchmark harness; the top recomputes widths from its parameters.
package pla_fsm_pkg;

    localparam int DEF_N_IN   = 6;
    localparam int DEF_N_ST   = 3;
    localparam int DEF_N_OUT  = 11;
    localparam int DEF_N_TERM = 32;
    localparam int DEF_CNT_W  = 16;

    localparam int X_W = DEF_N_ST + DEF_N_IN;
    localparam int R_W = DEF_N_ST + DEF_N_OUT;

    // Output vectors up to 64 bits wide; the count fits in 8 bits.
    function automatic logic [7:0] popcount(input logic [63:0] v);
        logic [7:0] c;
        c = '0;
        for (int i = 0; i < 64; i++) begin
            c = c + 8'(v[i]);
        end
        return c;
    endfunction

endpackage

// File: rtl/pla_fsm_engine_term.sv
// One product-term slot: valid/mask/value/OR-row storage and the AND-plane hit test.
// Only the valid bit is reset; an out-of-range address never matches any slot index.
module pla_term_match #(
    parameter int X_W = 9,
    parameter int R_W = 14,
    parameter int A_W = 5,
    parameter int IDX = 0
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           we,
    input  logic [A_W-1:0] addr,
    input  logic           cfg_valid,
    input  logic [X_W-1:0] cfg_mask,
    input  logic [X_W-1:0] cfg_val,
    input  logic [R_W-1:0] cfg_or,
    input  logic [X_W-1:0] x,
    output logic           hit,
    output logic [R_W-1:0] row
);

    localparam logic [A_W-1:0] SLOT = A_W'(IDX);

    logic           valid;
    logic [X_W-1:0] mask;
    logic [X_W-1:0] val;
    logic [R_W-1:0] or_row;
    logic           sel;

    assign sel = we && (addr == SLOT);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid <= 1'b0;
        end else if (sel) begin
            valid <= cfg_valid;
        end
    end

    always_ff @(posedge clk) begin
        if (sel) begin
            mask   <= cfg_mask;
            val    <= cfg_val;
            or_row <= cfg_or;
        end
    end

    assign hit = valid && (((x ^ val) & mask) == '0);
    assign row = or_row;

endmodule

// File: rtl/pla_fsm_engine.sv
// Run-time programmable two-level FSM: term slots evaluated over {state, inputs} yield the
// next state and outputs, which are registered along with a saturating output-toggle counter.
module pla_fsm_engine
    import pla_fsm_pkg::*;
#(
    parameter int              N_IN      = DEF_N_IN,
    parameter int              N_ST      = DEF_N_ST,
    parameter int              N_OUT     = DEF_N_OUT,
    parameter int              N_TERM    = DEF_N_TERM,
    parameter logic [N_ST-1:0] RST_STATE = '0,
    parameter int              CNT_W     = DEF_CNT_W,
    localparam int             A_W       = (N_TERM > 1) ? $clog2(N_TERM) : 1,
    localparam int             XW        = N_ST + N_IN,
    localparam int             RW        = N_ST + N_OUT
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N_IN-1:0]  in_i,
    input  logic             en_i,
    input  logic             cfg_we_i,
    input  logic [A_W-1:0]   cfg_addr_i,
    input  logic             cfg_valid_i,
    input  logic [XW-1:0]    cfg_mask_i,
    input  logic [XW-1:0]    cfg_val_i,
    input  logic [RW-1:0]    cfg_or_i,
    input  logic             clr_i,
    output logic [N_ST-1:0]  state_o,
    output logic [N_OUT-1:0] out_o,
    output logic             idle_o,
    output logic [CNT_W-1:0] toggle_o
);

    localparam int SUM_W = CNT_W + 8;

    logic [XW-1:0]    x;
    logic [N_TERM-1:0] hits;
    logic [RW-1:0]    rows [N_TERM];
    logic [RW-1:0]    nxt;
    logic             any_hit;
    logic [N_OUT-1:0] new_out;
    logic [SUM_W-1:0] sum;
    logic [CNT_W-1:0] sat_sum;

    assign x = {state_o, in_i};

    for (genvar g = 0; g < N_TERM; g++) begin : g_term
        pla_term_match #(
            .X_W (XW),
            .R_W (RW),
            .A_W (A_W),
            .IDX (g)
        ) u_term (
            .clk       (clk),
            .rst_n     (rst_n),
            .we        (cfg_we_i),
            .addr      (cfg_addr_i),
            .cfg_valid (cfg_valid_i),
            .cfg_mask  (cfg_mask_i),
            .cfg_val   (cfg_val_i),
            .cfg_or    (cfg_or_i),
            .x         (x),
            .hit       (hits[g]),
            .row       (rows[g])
        );
    end

    always_comb begin
        nxt = '0;
        for (int i = 0; i < N_TERM; i++) begin
            if (hits[i]) begin
                nxt = nxt | rows[i];
            end
        end
    end

    assign any_hit = |hits;
    assign new_out = any_hit ? nxt[N_OUT-1:0] : '0;

    // Extra headroom bits make saturation a simple overflow check.
    assign sum     = SUM_W'(toggle_o) + SUM_W'(popcount(64'(out_o ^ new_out)));
    assign sat_sum = (|sum[SUM_W-1:CNT_W]) ? '1 : sum[CNT_W-1:0];

    // en_i is a single-cycle step strobe: every cycle it is high evaluates the table once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_o  <= RST_STATE;
            out_o    <= '0;
            idle_o   <= 1'b0;
            toggle_o <= '0;
        end else begin
            if (en_i) begin
                out_o  <= new_out;
                idle_o <= !any_hit;
                if (any_hit) begin
                    state_o <= nxt[RW-1:N_OUT];
                end
            end
            if (clr_i) begin
                toggle_o <= '0;
            end else if (en_i) begin
                toggle_o <= sat_sum;
            end
        end
    end

endmodule

// File: tb/tb_pla_fsm_engine.sv
// Directed bench for pla_fsm_engine: a default instance plus a CNT_W=4 instance sharing stimulus.
module tb_pla_fsm_engine;

    logic        clk;
    logic        rst_n;
    logic [5:0]  in_i;
    logic        en_i;
    logic        cfg_we_i;
    logic [4:0]  cfg_addr_i;
    logic        cfg_valid_i;
    logic [8:0]  cfg_mask_i;
    logic [8:0]  cfg_val_i;
    logic [13:0] cfg_or_i;
    logic        clr_i;

    logic [2:0]  state_o;
    logic [10:0] out_o;
    logic        idle_o;
    logic [15:0] toggle_o;

    logic [2:0]  state4;
    logic [10:0] out4;
    logic        idle4;
    logic [3:0]  toggle4;

    int n_cmp;
    int n_bad;

    pla_fsm_engine dut (
        .clk (clk), .rst_n (rst_n), .in_i (in_i), .en_i (en_i),
        .cfg_we_i (cfg_we_i), .cfg_addr_i (cfg_addr_i), .cfg_valid_i (cfg_valid_i),
        .cfg_mask_i (cfg_mask_i), .cfg_val_i (cfg_val_i), .cfg_or_i (cfg_or_i),
        .clr_i (clr_i), .state_o (state_o), .out_o (out_o), .idle_o (idle_o),
        .toggle_o (toggle_o)
    );

    pla_fsm_engine #(.CNT_W(4)) dut4 (
        .clk (clk), .rst_n (rst_n), .in_i (in_i), .en_i (en_i),
        .cfg_we_i (cfg_we_i), .cfg_addr_i (cfg_addr_i), .cfg_valid_i (cfg_valid_i),
        .cfg_mask_i (cfg_mask_i), .cfg_val_i (cfg_val_i), .cfg_or_i (cfg_or_i),
        .clr_i (clr_i), .state_o (state4), .out_o (out4), .idle_o (idle4),
        .toggle_o (toggle4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic step(input logic [5:0] in_v);
        in_i = in_v;
        en_i = 1'b1;
        cycle();
        en_i = 1'b0;
    endtask

    task automatic write_slot(input logic [4:0] a, input logic v, input logic [8:0] m,
                              input logic [8:0] val, input logic [13:0] r);
        cfg_we_i    = 1'b1;
        cfg_addr_i  = a;
        cfg_valid_i = v;
        cfg_mask_i  = m;
        cfg_val_i   = val;
        cfg_or_i    = r;
        cycle();
        cfg_we_i    = 1'b0;
    endtask

    task automatic check_all(input string tag, input logic [2:0] st, input logic [10:0] o,
                             input logic idl, input logic [15:0] tg);
        check_eq({tag, ".state"}, 32'(state_o), 32'(st));
        check_eq({tag, ".out"}, 32'(out_o), 32'(o));
        check_eq({tag, ".idle"}, 32'(idle_o), 32'(idl));
        check_eq({tag, ".toggle"}, 32'(toggle_o), 32'(tg));
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        rst_n = 1'b0;
        in_i = '0; en_i = 1'b0; clr_i = 1'b0;
        cfg_we_i = 1'b0; cfg_addr_i = '0; cfg_valid_i = 1'b0;
        cfg_mask_i = '0; cfg_val_i = '0; cfg_or_i = '0;
        cycle();
        cycle();
        check_all("reset", 3'd0, 11'h000, 1'b0, 16'd0);
        rst_n = 1'b1;
        cycle();

        // empty table: no hit
        step(6'd0);
        check_all("empty", 3'd0, 11'h000, 1'b1, 16'd0);

        // always-hit slot0
        write_slot(5'd0, 1'b1, 9'h000, 9'h000, {3'b001, 11'h005});
        step(6'd0);
        check_all("slot0", 3'd1, 11'h005, 1'b0, 16'd2);

        // slot1 keyed on state 1, ORed with slot0
        write_slot(5'd1, 1'b1, 9'b111_000000, 9'b001_000000, {3'b010, 11'h400});
        step(6'd0);
        check_all("slot01", 3'd3, 11'h405, 1'b0, 16'd3);

        // invalidate slot0 in the same cycle as a step: old table still used
        cfg_we_i = 1'b1; cfg_addr_i = 5'd0; cfg_valid_i = 1'b0;
        cfg_mask_i = '0; cfg_val_i = '0; cfg_or_i = '0;
        step(6'd0);
        cfg_we_i = 1'b0;
        check_all("wr_same", 3'd1, 11'h005, 1'b0, 16'd4);
        step(6'd0);
        check_all("wr_after", 3'd2, 11'h400, 1'b0, 16'd7);
        step(6'd0);
        check_all("nohit", 3'd2, 11'h000, 1'b1, 16'd8);

        // en_i low holds everything
        in_i = 6'h3F;
        cycle();
        check_all("hold", 3'd2, 11'h000, 1'b1, 16'd8);

        // input-keyed slot2
        write_slot(5'd2, 1'b1, 9'b000_000001, 9'b000_000001, {3'b100, 11'h0F0});
        step(6'd0);
        check_all("in_miss", 3'd2, 11'h000, 1'b1, 16'd8);
        step(6'd1);
        check_all("in_hit", 3'd4, 11'h0F0, 1'b0, 16'd12);

        // saturation on the 4-bit counter
        clr_i = 1'b1;
        cycle();
        clr_i = 1'b0;
        check_eq("clr.toggle", 32'(toggle_o), 32'd0);
        check_eq("clr.toggle4", 32'(toggle4), 32'd0);
        write_slot(5'd1, 1'b0, 9'h000, 9'h000, 14'h0);
        write_slot(5'd2, 1'b0, 9'h000, 9'h000, 14'h0);
        write_slot(5'd0, 1'b1, 9'b000_000010, 9'b000_000010, {3'b000, 11'h7FF});
        step(6'd2);
        check_eq("sat1.out", 32'(out4), 32'h7FF);
        check_eq("sat1.state", 32'(state4), 32'd0);
        check_eq("sat1.toggle4", 32'(toggle4), 32'd7);
        step(6'd0);
        check_eq("sat2.out", 32'(out4), 32'h000);
        check_eq("sat2.toggle4", 32'(toggle4), 32'd15);
        step(6'd2);
        check_eq("sat3.toggle4", 32'(toggle4), 32'd15);
        check_eq("sat3.toggle", 32'(toggle_o), 32'd29);

        // clear wins over a simultaneous step
        clr_i = 1'b1;
        step(6'd0);
        clr_i = 1'b0;
        check_eq("clrstep.toggle4", 32'(toggle4), 32'd0);
        check_all("clrstep", 3'd0, 11'h000, 1'b1, 16'd0);

        // reset mid-operation with a write in flight
        write_slot(5'd4, 1'b1, 9'h000, 9'h000, {3'b110, 11'h123});
        step(6'd0);
        check_all("pre_rst", 3'd6, 11'h123, 1'b0, 16'd4);
        cfg_we_i = 1'b1; cfg_addr_i = 5'd5; cfg_valid_i = 1'b1;
        cfg_mask_i = '0; cfg_val_i = '0; cfg_or_i = {3'b111, 11'h7FF};
        #2;
        rst_n = 1'b0;
        #1;
        check_all("async_rst", 3'd0, 11'h000, 1'b0, 16'd0);
        cycle();
        cfg_we_i = 1'b0;
        rst_n = 1'b1;
        cycle();
        step(6'd0);
        check_all("post_rst", 3'd0, 11'h000, 1'b1, 16'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
